backward_propagation: RTL
=========================

// Module: backward_propagation
// PURPOSE
//  Training-direction partner of forward_propagation in the 2-2-1 XOR network. Consumes the
//  forward results (h1, h2, y), the inputs, a target and the current weights/biases.
//  Computes the sigmoid/MSE gradients with one shared saturating 8.8 multiplier, sequenced
//  by an FSM, and returns the SGD-updated weights/biases with a bp_valid handshake.
// PARAMETERS
//  dataWidth  16  signed fixed-point word width, all data ports
//  FRAC       8   fractional bits (8.8 format)
// PORTS
//  clk                         in   1   rising-edge clock, single clock domain
//  rst_n                       in   1   asynchronous, active-low reset
//  enable_bp                   in   1   level start request (same usage as enable_fp)
//  x1, x2                      in   16  network inputs, 8.8 signed
//  h1, h2, y                   in   16  forward sigmoid outputs, 8.8, range [0,1]
//  target                      in   16  desired y, 8.8 signed
//  lr                          in   16  learning rate, 8.8 signed
//  w11,w12,w21,w22,w31,w32     in   16  current weights (h1=sig(w11*x1+w12*x2+b1), h2 uses w21/w22)
//  b1, b2, b3                  in   16  current biases
//  w11_out..w32_out, b1_out..b3_out  out  16 each  updated weights/biases, registered
//  bp_valid                    out  1   results valid, held until enable_bp drops
// BEHAVIOUR
//  Reset: async on rst_n low; all *_out = 16'h0000, bp_valid = 0, FSM -> IDLE, step counter 0.
//  Arithmetic: mul = (a*b) 32-bit signed, >>> FRAC (floor), saturate to [16'h8000,16'h7FFF];
//   add/sub saturate likewise; no wrap anywhere. One multiply issued per cycle.
//  FSM: IDLE -> OUT_D(2) -> HID_D(6) -> GRAD(6) -> UPD(9) -> DONE; (n) = cycles in state.
//   IDLE:  on edge with enable_bp=1, latch all data inputs (edge 0); later input changes ignored.
//   OUT_D: e=sat(y-target); d3 = (y*(1-y))*e.
//   HID_D: d1 = (d3*w31)*(h1*(1-h1)); d2 = (d3*w32)*(h2*(1-h2)); uses OLD w31/w32.
//   GRAD:  g31=d3*h1, g32=d3*h2, g11=d1*x1, g12=d1*x2, g21=d2*x1, g22=d2*x2; gb3=d3,gb1=d1,gb2=d2.
//   UPD:   p = p - lr*g for the 9 params, one per cycle, order w31,w32,b3,w11,w12,b1,w21,w22,b2.
//   DONE:  all 9 *_out registers load simultaneously on the entry edge; bp_valid=1 on edge 24.
//  Latency: bp_valid rises exactly 24 clk edges after the start edge; *_out stable from then.
//  Handshake: bp_valid holds while enable_bp=1; on first edge with enable_bp=0 in DONE:
//   bp_valid=0, FSM->IDLE, *_out keep their values. enable_bp drop mid-run is ignored
//   (run completes). enable_bp held high after DONE never triggers a second run; a new
//   run needs enable_bp low for >=1 edge, then high.
//  *_out are not disturbed mid-run; they change only at DONE entry or reset.
//  Reset mid-run: abort immediately, outputs to reset values; no partial results escape.
// STRUCTURE
//  xor_nn_pkg: DATA_W=16, FRAC=8, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000, ONE=16'h0100,
//   FSM state enum, step-count constants (2/6/6/9).
//  Sub-module fxp_mul_sat: combinational signed 8.8 multiply, floor shift, saturate;
//   single instance, operands muxed by FSM step. Saturating add/sub as package functions.
// TESTING
//  1 y=target=0x0080, any weights, lr=0x0100 -> all *_out equal inputs, bp_valid at edge 24.
//  2 x1=x2=0x0100, h1=h2=y=0x0080, target=0, lr=0x0100, all w/b=0x0100 -> w31=w32=0x00F0,
//    b3=0x00E0, w11=w12=w21=w22=0x00F8, b1=b2=0x00F8.
//  3 y=0x0080, target=0x8000, lr=0x7FFF, b3=0x8000 -> e saturates 0x7FFF, d3=0x1FFF,
//    b3_out=0x8000 (saturated, not wrapped).
//  4 test 2 stimulus, rst_n low at edge 10 -> bp_valid=0, *_out=0 at once; rerun gives test 2 result.
//  5 enable_bp held high 50 cycles after DONE -> bp_valid stays 1, one run only; drop -> 0 next
//    edge; enable_bp dropped at edge 5 of a run -> run still completes at edge 24.
//  6 inputs changed at edge 3 of a run -> result matches values latched at start.

Source files
------------

// File: rtl/xor_nn_pkg.sv
// Shared fixed-point constants, FSM encodings and saturating helpers for the 2-2-1 XOR network.
// All data is signed 8.8; every arithmetic result clamps to [0x8000, 0x7FFF] instead of wrapping.
package xor_nn_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC   = 8;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;
  localparam logic [DATA_W-1:0] ONE     = 16'h0100;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] OUT_D = 3'd1;
  localparam logic [2:0] HID_D = 3'd2;
  localparam logic [2:0] GRAD  = 3'd3;
  localparam logic [2:0] UPD   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [3:0] OUT_N  = 4'd2;
  localparam logic [3:0] HID_N  = 4'd6;
  localparam logic [3:0] GRAD_N = 4'd6;
  localparam logic [3:0] UPD_N  = 4'd9;

  function automatic logic [DATA_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) return SAT_MAX;
    if (v < -32'sd32768) return SAT_MIN;
    return v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] add_sat(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [31:0] s;
    s = 32'($signed(a)) + 32'($signed(b));
    return sat16(s);
  endfunction

  function automatic logic [DATA_W-1:0] sub_sat(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [31:0] s;
    s = 32'($signed(a)) - 32'($signed(b));
    return sat16(s);
  endfunction
endpackage

// File: rtl/fxp_mul_sat.sv
// Combinational signed 8.8 multiply: full 32-bit product, floor shift by FRAC, clamp to 16 bits.
module fxp_mul_sat
  import xor_nn_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p
);
  logic signed [31:0] prod;
  logic signed [31:0] shifted;

  assign prod    = $signed(a) * $signed(b);
  assign shifted = prod >>> FRAC;
  assign p       = sat16(shifted);
endmodule

// File: rtl/backward_propagation.sv
// SGD backward pass for the 2-2-1 XOR net: one shared saturating multiplier sequenced by an FSM.
// bp_valid rises 24 edges after the start edge and holds until enable_bp drops.
module backward_propagation
  import xor_nn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_bp,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] h1,
  input  logic [DATA_W-1:0] h2,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] target,
  input  logic [DATA_W-1:0] lr,
  input  logic [DATA_W-1:0] w11,
  input  logic [DATA_W-1:0] w12,
  input  logic [DATA_W-1:0] w21,
  input  logic [DATA_W-1:0] w22,
  input  logic [DATA_W-1:0] w31,
  input  logic [DATA_W-1:0] w32,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] b2,
  input  logic [DATA_W-1:0] b3,
  output logic [DATA_W-1:0] w11_out,
  output logic [DATA_W-1:0] w12_out,
  output logic [DATA_W-1:0] w21_out,
  output logic [DATA_W-1:0] w22_out,
  output logic [DATA_W-1:0] w31_out,
  output logic [DATA_W-1:0] w32_out,
  output logic [DATA_W-1:0] b1_out,
  output logic [DATA_W-1:0] b2_out,
  output logic [DATA_W-1:0] b3_out,
  output logic              bp_valid
);
  logic [2:0]        state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] lx1, lx2, lh1, lh2, ly, ltgt, llr;
  // Parameters held in update order: w31,w32,b3,w11,w12,b1,w21,w22,b2
  logic [DATA_W-1:0] p [0:8];
  logic [DATA_W-1:0] t1, t2, d1, d2, d3;
  logic [DATA_W-1:0] g31, g32, g11, g12, g21, g22;
  logic [DATA_W-1:0] ma, mb, prod, gsel;

  fxp_mul_sat u_mul (.a(ma), .b(mb), .p(prod));

  always_comb begin
    gsel = '0;
    case (cnt)
      4'd0: gsel = g31;
      4'd1: gsel = g32;
      4'd2: gsel = d3;
      4'd3: gsel = g11;
      4'd4: gsel = g12;
      4'd5: gsel = d1;
      4'd6: gsel = g21;
      4'd7: gsel = g22;
      4'd8: gsel = d2;
      default: gsel = '0;
    endcase
  end

  always_comb begin
    ma = '0;
    mb = '0;
    case (state)
      OUT_D: begin
        if (cnt == 4'd0) begin ma = ly; mb = sub_sat(ONE, ly); end
        else             begin ma = t1; mb = sub_sat(ly, ltgt); end
      end
      HID_D: begin
        case (cnt)
          4'd0: begin ma = d3;  mb = p[0]; end
          4'd1: begin ma = lh1; mb = sub_sat(ONE, lh1); end
          4'd3: begin ma = d3;  mb = p[1]; end
          4'd4: begin ma = lh2; mb = sub_sat(ONE, lh2); end
          default: begin ma = t1; mb = t2; end
        endcase
      end
      GRAD: begin
        case (cnt)
          4'd0: begin ma = d3; mb = lh1; end
          4'd1: begin ma = d3; mb = lh2; end
          4'd2: begin ma = d1; mb = lx1; end
          4'd3: begin ma = d1; mb = lx2; end
          4'd4: begin ma = d2; mb = lx1; end
          default: begin ma = d2; mb = lx2; end
        endcase
      end
      UPD: begin ma = llr; mb = gsel; end
      default: begin ma = '0; mb = '0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      {lx1, lx2, lh1, lh2, ly, ltgt, llr} <= '0;
      for (int i = 0; i < 9; i++) p[i] <= '0;
      {t1, t2, d1, d2, d3} <= '0;
      {g31, g32, g11, g12, g21, g22} <= '0;
      {w11_out, w12_out, w21_out, w22_out, w31_out, w32_out} <= '0;
      {b1_out, b2_out, b3_out} <= '0;
      bp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable_bp) begin
          {lx1, lx2, lh1, lh2, ly, ltgt, llr} <= {x1, x2, h1, h2, y, target, lr};
          p[0] <= w31; p[1] <= w32; p[2] <= b3;
          p[3] <= w11; p[4] <= w12; p[5] <= b1;
          p[6] <= w21; p[7] <= w22; p[8] <= b2;
          state <= OUT_D;
          cnt   <= '0;
        end
        OUT_D: begin
          if (cnt == 4'd0) t1 <= prod;
          else             d3 <= prod;
          if (cnt == OUT_N - 4'd1) begin state <= HID_D; cnt <= '0; end
          else cnt <= cnt + 4'd1;
        end
        HID_D: begin
          case (cnt)
            4'd0, 4'd3: t1 <= prod;
            4'd1, 4'd4: t2 <= prod;
            4'd2:       d1 <= prod;
            default:    d2 <= prod;
          endcase
          if (cnt == HID_N - 4'd1) begin state <= GRAD; cnt <= '0; end
          else cnt <= cnt + 4'd1;
        end
        GRAD: begin
          case (cnt)
            4'd0:    g31 <= prod;
            4'd1:    g32 <= prod;
            4'd2:    g11 <= prod;
            4'd3:    g12 <= prod;
            4'd4:    g21 <= prod;
            default: g22 <= prod;
          endcase
          if (cnt == GRAD_N - 4'd1) begin state <= UPD; cnt <= '0; end
          else cnt <= cnt + 4'd1;
        end
        UPD: begin
          // The extra cycle after the ninth update publishes all results on one edge
          if (cnt == UPD_N) begin
            w31_out <= p[0]; w32_out <= p[1]; b3_out <= p[2];
            w11_out <= p[3]; w12_out <= p[4]; b1_out <= p[5];
            w21_out <= p[6]; w22_out <= p[7]; b2_out <= p[8];
            bp_valid <= 1'b1;
            state    <= DONE;
            cnt      <= '0;
          end else begin
            p[cnt] <= sub_sat(p[cnt], prod);
            cnt    <= cnt + 4'd1;
          end
        end
        DONE: if (!enable_bp) begin
          bp_valid <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule
